// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory access controller: funct3 codes,
// controller state encoding and the byte-lane mask helper.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_MERGE  = 2'd2
  } state_t;

  // Lanes touched by an access of the given size at byte offset off.
  function automatic logic [3:0] lane_mask(input logic [2:0] funct3, input logic [1:0] off);
    case (funct3)
      F3_B, F3_BU: lane_mask = 4'b0001 << off;
      F3_H, F3_HU: lane_mask = 4'b0011 << off;
      default:     lane_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// Combinational lane logic: load extract/extend and sub-word store merge
// for little-endian RV32 byte/half/word accesses.
module dmem_lane_unit
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  input  logic [31:0] old_word,
  input  logic [15:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] wrep;
  logic [3:0]  mask;

  always_comb begin
    case (offset)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = offset[1] ? word[31:16] : word[15:0];

    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_data = {24'h0, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_data = {16'h0, half_sel};
      default: load_data = word;
    endcase

    // Replicate the store data across all lanes, then let the mask pick.
    wrep = (funct3 == F3_H) ? {2{wdata}} : {4{wdata[7:0]}};
    mask = lane_mask(funct3, offset);
    merge_data = old_word;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) merge_data[8*i +: 8] = wrep[8*i +: 8];
    end
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Two-port round-robin load/store controller in front of a single-port,
// word-organised data memory; sub-word stores use read-modify-write.
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int WIDTH_ADDR = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  p0_req_valid,
  output logic                  p0_req_ready,
  input  logic                  p0_req_we,
  input  logic [2:0]            p0_req_funct3,
  input  logic [31:0]           p0_req_addr,
  input  logic [31:0]           p0_req_wdata,
  output logic                  p0_rsp_valid,
  output logic [31:0]           p0_rsp_rdata,
  output logic                  p0_rsp_err,
  input  logic                  p1_req_valid,
  output logic                  p1_req_ready,
  input  logic                  p1_req_we,
  input  logic [2:0]            p1_req_funct3,
  input  logic [31:0]           p1_req_addr,
  input  logic [31:0]           p1_req_wdata,
  output logic                  p1_rsp_valid,
  output logic [31:0]           p1_rsp_rdata,
  output logic                  p1_rsp_err,
  output logic                  mem_we,
  output logic [WIDTH_ADDR-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  state_t      state, state_nxt;
  logic        rr;
  logic        owner;
  logic        grant0, grant1, accept;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q, wdata_q, old_q;
  logic        illegal, misaligned, out_of_range, err, sub_store;
  logic [31:0] load_data, merge_data;
  logic        rsp_fire, rsp_err_c;
  logic [31:0] rsp_data;

  // rr holds the last owner; the other port wins a tie.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == S_IDLE) begin
      grant0 = p0_req_valid & (~p1_req_valid | rr);
      grant1 = p1_req_valid & (~p0_req_valid | ~rr);
    end
  end

  assign p0_req_ready = grant0;
  assign p1_req_ready = grant1;
  assign accept       = grant0 | grant1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      rr    <= 1'b1;
      owner <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        rr    <= grant1;
        owner <= grant1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= grant1 ? p1_req_we     : p0_req_we;
      f3_q    <= grant1 ? p1_req_funct3 : p0_req_funct3;
      addr_q  <= grant1 ? p1_req_addr   : p0_req_addr;
      wdata_q <= grant1 ? p1_req_wdata  : p0_req_wdata;
    end
    if (state == S_ACCESS) old_q <= mem_rdata;
  end

  always_comb begin
    illegal      = (f3_q == 3'b011) | (f3_q == 3'b110) | (f3_q == 3'b111) |
                   (we_q & ((f3_q == F3_BU) | (f3_q == F3_HU)));
    misaligned   = (((f3_q == F3_H) | (f3_q == F3_HU)) & addr_q[0]) |
                   ((f3_q == F3_W) & (addr_q[1:0] != 2'b00));
    out_of_range = |addr_q[31:WIDTH_ADDR+2];
    err          = illegal | misaligned | out_of_range;
    // Only SB/SH survive the error check as non-word stores.
    sub_store    = we_q & (f3_q != F3_W);
  end

  dmem_lane_unit u_lane (
    .word       (mem_rdata),
    .offset     (addr_q[1:0]),
    .funct3     (f3_q),
    .old_word   (old_q),
    .wdata      (wdata_q[15:0]),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (accept) state_nxt = S_ACCESS;
      S_ACCESS: state_nxt = (!err && sub_store) ? S_MERGE : S_IDLE;
      S_MERGE:  state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    busy      = (state != S_IDLE);
    rsp_fire  = 1'b0;
    rsp_err_c = 1'b0;
    rsp_data  = '0;
    case (state)
      S_ACCESS: begin
        mem_addr = addr_q[WIDTH_ADDR+1:2];
        if (err) begin
          rsp_fire  = 1'b1;
          rsp_err_c = 1'b1;
        end else if (!we_q) begin
          rsp_fire = 1'b1;
          rsp_data = load_data;
        end else if (!sub_store) begin
          rsp_fire  = 1'b1;
          mem_we    = 1'b1;
          mem_wdata = wdata_q;
        end
      end
      S_MERGE: begin
        mem_addr  = addr_q[WIDTH_ADDR+1:2];
        mem_we    = 1'b1;
        mem_wdata = merge_data;
        rsp_fire  = 1'b1;
      end
      default: ;
    endcase
  end

  // Responses are registered and steered to the owner only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0_rsp_valid <= 1'b0;
      p0_rsp_rdata <= '0;
      p0_rsp_err   <= 1'b0;
      p1_rsp_valid <= 1'b0;
      p1_rsp_rdata <= '0;
      p1_rsp_err   <= 1'b0;
    end else begin
      p0_rsp_valid <= rsp_fire & ~owner;
      p0_rsp_rdata <= (rsp_fire & ~owner) ? rsp_data : '0;
      p0_rsp_err   <= rsp_fire & ~owner & rsp_err_c;
      p1_rsp_valid <= rsp_fire & owner;
      p1_rsp_rdata <= (rsp_fire & owner) ? rsp_data : '0;
      p1_rsp_err   <= rsp_fire & owner & rsp_err_c;
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: directed and random accesses checked against a
// byte-level memory model with an independent error/extension model.
module tb_dmem_access_ctrl;
  import dmem_pkg::*;

  localparam int WA = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          p0_req_valid, p0_req_ready, p0_req_we;
  logic [2:0]    p0_req_funct3;
  logic [31:0]   p0_req_addr, p0_req_wdata;
  logic          p0_rsp_valid, p0_rsp_err;
  logic [31:0]   p0_rsp_rdata;
  logic          p1_req_valid, p1_req_ready, p1_req_we;
  logic [2:0]    p1_req_funct3;
  logic [31:0]   p1_req_addr, p1_req_wdata;
  logic          p1_rsp_valid, p1_rsp_err;
  logic [31:0]   p1_rsp_rdata;
  logic          mem_we;
  logic [WA-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;
  logic          busy;

  logic [31:0]   tb_mem  [0:255];
  logic [31:0]   ref_mem [0:255];
  logic          bd_we = 1'b0;
  logic [WA-1:0] bd_addr = '0;
  logic [31:0]   bd_data = '0;
  int            wr_count = 0;
  int            n_cmp = 0;
  int            n_fail = 0;
  int            ref_rr = 1;

  always #5 clk = ~clk;

  dmem_access_ctrl #(.WIDTH_ADDR(WA), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_we(p0_req_we),
    .p0_req_funct3(p0_req_funct3), .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata),
    .p0_rsp_valid(p0_rsp_valid), .p0_rsp_rdata(p0_rsp_rdata), .p0_rsp_err(p0_rsp_err),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_we(p1_req_we),
    .p1_req_funct3(p1_req_funct3), .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata),
    .p1_rsp_valid(p1_rsp_valid), .p1_rsp_rdata(p1_rsp_rdata), .p1_rsp_err(p1_rsp_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  // Memory environment: combinational read, write on the clock edge.
  assign mem_rdata = tb_mem[mem_addr];
  always @(posedge clk) begin
    if (bd_we) tb_mem[bd_addr] <= bd_data;
    else if (mem_we) begin
      tb_mem[mem_addr] <= mem_wdata;
      wr_count <= wr_count + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int model_size(input logic [2:0] f3);
    if (f3 == F3_B || f3 == F3_BU) return 1;
    if (f3 == F3_H || f3 == F3_HU) return 2;
    return 4;
  endfunction

  function automatic logic model_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
    if (!(f3 == F3_B || f3 == F3_H || f3 == F3_W || f3 == F3_BU || f3 == F3_HU)) return 1'b1;
    if (we && (f3 == F3_BU || f3 == F3_HU)) return 1'b1;
    if ((a >> (WA + 2)) != 0) return 1'b1;
    if ((a % model_size(f3)) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [7:0] byte_at(input logic [31:0] a);
    logic [31:0] s;
    s = ref_mem[(a >> 2) & 255] >> (8 * (a & 3));
    return s[7:0];
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    longint v;
    int     sz;
    logic [63:0] r;
    sz = model_size(f3);
    v  = 0;
    for (int i = 0; i < sz; i++) v += longint'(byte_at(a + i)) << (8 * i);
    if ((f3 == F3_B || f3 == F3_H || f3 == F3_W) && v >= (longint'(1) << (8 * sz - 1)))
      v -= longint'(1) << (8 * sz);
    r = 64'(v);
    return r[31:0];
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    int idx, ofs;
    logic [31:0] b;
    for (int i = 0; i < model_size(f3); i++) begin
      idx = int'(((a + i) >> 2) & 255);
      ofs = int'((a + i) & 3);
      b   = (wd >> (8 * i)) & 32'hFF;
      ref_mem[idx] = (ref_mem[idx] & ~(32'hFF << (8 * ofs))) | (b << (8 * ofs));
    end
  endtask

  task automatic set_req(input int p, input logic v, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
    if (p == 0) begin
      p0_req_valid = v; p0_req_we = we; p0_req_funct3 = f3; p0_req_addr = a; p0_req_wdata = wd;
    end else begin
      p1_req_valid = v; p1_req_we = we; p1_req_funct3 = f3; p1_req_addr = a; p1_req_wdata = wd;
    end
  endtask

  function automatic logic get_ready(input int p);
    return (p == 0) ? p0_req_ready : p1_req_ready;
  endfunction
  function automatic logic get_rsp_valid(input int p);
    return (p == 0) ? p0_rsp_valid : p1_rsp_valid;
  endfunction
  function automatic logic [31:0] get_rsp_rdata(input int p);
    return (p == 0) ? p0_rsp_rdata : p1_rsp_rdata;
  endfunction
  function automatic logic get_rsp_err(input int p);
    return (p == 0) ? p0_rsp_err : p1_rsp_err;
  endfunction

  // One complete access on one port, checked against the model.
  task automatic do_op(input int port, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input string tag,
                       output logic [31:0] rd);
    logic        e;
    logic [31:0] exp_rd;
    int          exp_lat, n, lat, w0, idx;
    e       = model_err(we, f3, a);
    exp_rd  = (e || we) ? 32'h0 : model_load(f3, a);
    exp_lat = (!e && we && (f3 == F3_B || f3 == F3_H)) ? 3 : 2;
    @(negedge clk);
    set_req(port, 1'b1, we, f3, a, wd);
    #1;
    n = 0;
    while (!get_ready(port) && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({tag, "_accept"}, 32'(n < 20), 32'h1);
    w0     = wr_count;
    ref_rr = port;
    @(negedge clk);
    set_req(port, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h1);
    lat = 1;
    while (!get_rsp_valid(port) && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    rd = get_rsp_rdata(port);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_rdata"}, rd, exp_rd);
    chk({tag, "_err"}, 32'(get_rsp_err(port)), 32'(e));
    chk({tag, "_other"}, 32'(get_rsp_valid(1 - port)), 32'h0);
    if (!e && we) model_store(f3, a, wd);
    chk({tag, "_writes"}, wr_count - w0, (!e && we) ? 1 : 0);
    idx = int'(a[WA+1:2]);
    chk({tag, "_mem"}, tb_mem[idx], ref_mem[idx]);
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(get_rsp_valid(port)), 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, a, wd, w0v;
    logic [2:0]  f3;
    logic        we;
    logic [1:0]  g, exp_g;
    logic [1:0]  exp_rsp [0:19];
    int          grants, port, n, w0;

    rst_n = 1'b0;
    set_req(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    set_req(1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);

    // Backdoor preload of the memory and the model during reset.
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      bd_we   = 1'b1;
      bd_addr = WA'(i);
      bd_data = (i == 16) ? 32'h8899AABB : $urandom;
      ref_mem[i] = bd_data;
    end
    @(negedge clk);
    bd_we = 1'b0;

    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_rsp", {p1_rsp_valid, p1_rsp_err, p0_rsp_valid, p0_rsp_err}, 32'h0);
    chk("rst_rdata", p0_rsp_rdata | p1_rsp_rdata, 32'h0);
    rst_n = 1'b1;
    ref_rr = 1;

    // Sub-word and word loads from the preloaded word.
    do_op(0, 1'b0, F3_B,  32'h43, 32'h0, "lb43", rd);  chk("lb43_const", rd, 32'hFFFFFF88);
    do_op(0, 1'b0, F3_BU, 32'h43, 32'h0, "lbu43", rd); chk("lbu43_const", rd, 32'h00000088);
    do_op(0, 1'b0, F3_H,  32'h42, 32'h0, "lh42", rd);  chk("lh42_const", rd, 32'hFFFF8899);
    do_op(0, 1'b0, F3_W,  32'h40, 32'h0, "lw40", rd);  chk("lw40_const", rd, 32'h8899AABB);

    // Read-modify-write stores.
    do_op(0, 1'b1, F3_B, 32'h41, 32'h55, "sb41", rd);
    chk("sb41_word", tb_mem[16], 32'h889955BB);
    do_op(0, 1'b1, F3_H, 32'h42, 32'h1234, "sh42", rd);
    chk("sh42_word", tb_mem[16], 32'h123455BB);

    // Both ports continuously valid: grants alternate, responses go to owner.
    for (int i = 0; i < 20; i++) exp_rsp[i] = 2'b00;
    grants = 0;
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, F3_W, 32'h0, 32'h0);
    set_req(1, 1'b1, 1'b0, F3_W, 32'h4, 32'h0);
    for (int c = 0; c < 16; c++) begin
      #1;
      g = {p1_req_ready, p0_req_ready};
      if (g != 2'b00) begin
        exp_g = (ref_rr == 1) ? 2'b01 : 2'b10;
        chk("arb_grant", 32'(g), 32'(exp_g));
        ref_rr = (exp_g == 2'b01) ? 0 : 1;
        exp_rsp[c+2] = exp_g;
        grants++;
      end
      chk("arb_rsp", 32'({p1_rsp_valid, p0_rsp_valid}), 32'(exp_rsp[c]));
      if (p0_rsp_valid) chk("arb_p0_rdata", p0_rsp_rdata, ref_mem[0]);
      if (p1_rsp_valid) chk("arb_p1_rdata", p1_rsp_rdata, ref_mem[1]);
      @(negedge clk);
    end
    set_req(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    set_req(1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    chk("arb_rsp_last", 32'({p1_rsp_valid, p0_rsp_valid}), 32'(exp_rsp[16]));
    chk("arb_grants", grants, 8);

    // Error cases: misaligned word, misaligned half store, out of range.
    do_op(0, 1'b0, F3_W, 32'h42,  32'h0,        "err_lw42", rd);
    do_op(0, 1'b1, F3_H, 32'h41,  32'hBEEF,     "err_sh41", rd);
    do_op(1, 1'b0, F3_W, 32'h400, 32'h0,        "err_lw400", rd);
    do_op(1, 1'b1, F3_BU, 32'h10, 32'h77,       "err_sbu", rd);

    // Random accesses on either port.
    for (int k = 0; k < 60; k++) begin
      port = int'($urandom_range(0, 1));
      we   = 1'($urandom_range(0, 1));
      f3   = 3'($urandom_range(0, 7));
      wd   = $urandom;
      if ($urandom_range(0, 9) < 8) begin
        a = 32'($urandom_range(0, 1023));
        if ($urandom_range(0, 9) < 7) a = a & ~32'(model_size(f3) - 1);
      end else begin
        a = $urandom;
      end
      do_op(port, we, f3, a, wd, "rand", rd);
    end

    // Reset during the merge cycle of a byte store abandons it.
    @(negedge clk);
    set_req(0, 1'b1, 1'b1, F3_B, 32'h40, 32'hA5);
    #1;
    n = 0;
    while (!p0_req_ready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("rstm_accept", 32'(n < 20), 32'h1);
    w0  = wr_count;
    w0v = tb_mem[16];
    @(negedge clk);
    set_req(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(negedge clk);
    chk("rstm_merge_we", 32'(mem_we), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rstm_we", 32'(mem_we), 32'h0);
    chk("rstm_busy", 32'(busy), 32'h0);
    chk("rstm_addr", 32'(mem_addr), 32'h0);
    chk("rstm_wdata", mem_wdata, 32'h0);
    chk("rstm_rsp", {p1_rsp_valid, p1_rsp_err, p0_rsp_valid, p0_rsp_err}, 32'h0);
    chk("rstm_rdata", p0_rsp_rdata | p1_rsp_rdata, 32'h0);
    @(negedge clk);
    chk("rstm_writes", wr_count - w0, 0);
    chk("rstm_mem", tb_mem[16], w0v);
    chk("rstm_model", tb_mem[16], ref_mem[16]);
    rst_n  = 1'b1;
    ref_rr = 1;
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, F3_W, 32'h40, 32'h0);
    set_req(1, 1'b1, 1'b0, F3_W, 32'h44, 32'h0);
    #1;
    exp_g = (ref_rr == 1) ? 2'b01 : 2'b10;
    chk("rstm_first_grant", 32'({p1_req_ready, p0_req_ready}), 32'(exp_g));
    @(negedge clk);
    set_req(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    set_req(1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(negedge clk);
    chk("rstm_post_rsp", 32'({p1_rsp_valid, p0_rsp_valid}), 32'(exp_g));
    chk("rstm_post_rdata", p0_rsp_rdata, ref_mem[16]);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
